// File: rtl/exc_commit_ctrl.sv
// Exception commit controller: prioritises commit-stage exceptions, interrupts
// and ERET, pulses CP0, flushes the pipeline, then hands a redirect PC to fetch.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_adel_if,
  input  logic        m_ri,
  input  logic        m_sys,
  input  logic        m_bp,
  input  logic        m_ov,
  input  logic        m_adel_d,
  input  logic        m_ades,
  input  logic        m_eret,
  input  logic [31:0] m_daddr,
  input  logic        interupt,
  input  logic        status_exl,
  input  logic [31:0] epc_in,
  output logic        execption,
  output logic        ret,          // ERET pulse to CP0
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr,
  output logic        flush,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [31:0] redir_pc
);

  // state    | meaning
  // IDLE     | accepting commit-stage instructions
  // FLUSH    | flush held high for FLUSH_CYCLES cycles
  // REDIRECT | offering redirect PC to fetch
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  flush_cnt;
  logic        int_pend;
  logic        accept;
  logic        exc_sel;
  logic [4:0]  sel_code;
  logic [31:0] sel_badv;
  logic        take_exc;
  logic        take_ret;

  assign m_ready     = (state == IDLE) & ~rst;
  assign accept      = m_valid & m_ready;
  assign flush       = (state == FLUSH);
  assign redir_valid = (state == REDIRECT);
  assign take_exc    = accept & exc_sel;
  assign take_ret    = accept & ~exc_sel & m_eret;

  always_comb begin
    exc_sel  = 1'b1;
    sel_code = 5'd0;
    sel_badv = 32'd0;
    if (int_pend) begin
      sel_code = 5'd0;
    end else if (m_adel_if) begin
      sel_code = 5'd4;
      sel_badv = m_pc;
    end else if (m_ri) begin
      sel_code = 5'd10;
    end else if (m_sys) begin
      sel_code = 5'd8;
    end else if (m_bp) begin
      sel_code = 5'd9;
    end else if (m_ov) begin
      sel_code = 5'd12;
    end else if (m_adel_d) begin
      sel_code = 5'd4;
      sel_badv = m_daddr;
    end else if (m_ades) begin
      sel_code = 5'd5;
      sel_badv = m_daddr;
    end else begin
      exc_sel = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take_exc || take_ret) state_nxt = FLUSH;
      FLUSH:    if (flush_cnt == 4'd0) state_nxt = REDIRECT;
      REDIRECT: if (redir_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_pend     <= 1'b0;
      flush_cnt    <= 4'd0;
      execption    <= 1'b0;
      ret          <= 1'b0;
      exc_code     <= 5'd0;
      exc_epc      <= 32'd0;
      exc_bd       <= 1'b0;
      exc_badvaddr <= 32'd0;
      redir_pc     <= 32'd0;
    end else begin
      // Taking the interrupt consumes it; otherwise track the gated level.
      if (take_exc && int_pend) int_pend <= 1'b0;
      else                      int_pend <= interupt & ~status_exl;

      execption <= take_exc;
      ret       <= take_ret;

      if (take_exc || take_ret)
        flush_cnt <= 4'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != 4'd0)
        flush_cnt <= flush_cnt - 4'd1;

      if (take_exc) begin
        exc_code     <= sel_code;
        exc_epc      <= m_bd ? m_pc - 32'd4 : m_pc;
        exc_bd       <= m_bd;
        exc_badvaddr <= sel_badv;
        redir_pc     <= EXC_VECTOR;
      end else if (take_ret) begin
        redir_pc     <= epc_in;
      end
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed self-checking bench for exc_commit_ctrl with hand-computed vectors.
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_ready;
  logic [31:0] m_pc;
  logic        m_bd, m_adel_if, m_ri, m_sys, m_bp, m_ov, m_adel_d, m_ades, m_eret;
  logic [31:0] m_daddr;
  logic        interupt, status_exl;
  logic [31:0] epc_in;
  logic        execption, ret;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        flush, redir_valid, redir_ready;
  logic [31:0] redir_pc;

  int errors = 0;
  int checks = 0;

  exc_commit_ctrl dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_bd(m_bd),
    .m_adel_if(m_adel_if), .m_ri(m_ri), .m_sys(m_sys), .m_bp(m_bp),
    .m_ov(m_ov), .m_adel_d(m_adel_d), .m_ades(m_ades), .m_eret(m_eret),
    .m_daddr(m_daddr), .interupt(interupt), .status_exl(status_exl),
    .epc_in(epc_in), .execption(execption), .ret(ret),
    .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .flush(flush), .redir_valid(redir_valid),
    .redir_ready(redir_ready), .redir_pc(redir_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_valid = 0; m_pc = 0; m_bd = 0; m_adel_if = 0; m_ri = 0; m_sys = 0;
    m_bp = 0; m_ov = 0; m_adel_d = 0; m_ades = 0; m_eret = 0; m_daddr = 0;
  endtask

  // Called in the first flush cycle: checks second flush cycle, redirect, handshake.
  task automatic finish_event(input string tag, input logic [31:0] exp_pc);
    tick();
    chk({tag, "_flush2"}, 32'(flush), 32'd1);
    chk({tag, "_pulse2"}, 32'(execption | ret), 32'd0);
    tick();
    chk({tag, "_flush_off"}, 32'(flush), 32'd0);
    chk({tag, "_rvalid"}, 32'(redir_valid), 32'd1);
    chk({tag, "_rpc"}, redir_pc, exp_pc);
    redir_ready = 1;
    tick();
    redir_ready = 0;
    chk({tag, "_rvalid_done"}, 32'(redir_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(m_ready), 32'd1);
  endtask

  initial begin
    clear_inputs();
    rst = 1; interupt = 0; status_exl = 0; epc_in = 0; redir_ready = 0;
    tick(); tick();
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rvalid", 32'(redir_valid), 32'd0);
    chk("rst_rpc", redir_pc, 32'd0);
    chk("rst_exc", 32'(execption | ret), 32'd0);
    rst = 0;
    #1;
    chk("rst_release_ready", 32'(m_ready), 32'd1);
    tick();

    // Overflow
    m_valid = 1; m_pc = 32'h80001000; m_ov = 1;
    tick(); clear_inputs();
    chk("ov_exc", 32'(execption), 32'd1);
    chk("ov_code", 32'(exc_code), 32'd12);
    chk("ov_epc", exc_epc, 32'h80001000);
    chk("ov_bd", 32'(exc_bd), 32'd0);
    chk("ov_badv", exc_badvaddr, 32'd0);
    chk("ov_flush1", 32'(flush), 32'd1);
    chk("ov_m_ready", 32'(m_ready), 32'd0);
    finish_event("ov", 32'hBFC00380);

    // Delay-slot store address error
    m_valid = 1; m_pc = 32'h80002004; m_bd = 1; m_ades = 1; m_daddr = 32'h00000003;
    tick(); clear_inputs();
    chk("ades_code", 32'(exc_code), 32'd5);
    chk("ades_epc", exc_epc, 32'h80002000);
    chk("ades_bd", 32'(exc_bd), 32'd1);
    chk("ades_badv", exc_badvaddr, 32'h00000003);
    finish_event("ades", 32'hBFC00380);

    // Fetch address error beats reserved instruction
    m_valid = 1; m_pc = 32'h80000002; m_adel_if = 1; m_ri = 1;
    tick(); clear_inputs();
    chk("prio_code", 32'(exc_code), 32'd4);
    chk("prio_badv", exc_badvaddr, 32'h80000002);
    finish_event("prio", 32'hBFC00380);

    // ERET with redirect back-pressure
    m_valid = 1; m_pc = 32'h80009000; m_eret = 1; epc_in = 32'h80003000;
    tick(); clear_inputs(); epc_in = 0;
    chk("eret_ret", 32'(ret), 32'd1);
    chk("eret_exc", 32'(execption), 32'd0);
    chk("eret_flush1", 32'(flush), 32'd1);
    tick();
    chk("eret_flush2", 32'(flush), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("eret_hold_valid", 32'(redir_valid), 32'd1);
      chk("eret_hold_pc", redir_pc, 32'h80003000);
      tick();
    end
    chk("eret_hold_valid_last", 32'(redir_valid), 32'd1);
    redir_ready = 1;
    tick();
    redir_ready = 0;
    chk("eret_done", 32'(redir_valid), 32'd0);

    // Interrupt masked by EXL: plain instruction retires
    interupt = 1; status_exl = 1;
    tick();
    m_valid = 1; m_pc = 32'h80004100;
    tick(); clear_inputs();
    chk("exl_no_exc", 32'(execption), 32'd0);
    chk("exl_no_flush", 32'(flush), 32'd0);
    chk("exl_ready", 32'(m_ready), 32'd1);
    // Unmask; idle cycle with m_valid=0 must not take it
    status_exl = 0;
    tick(); tick();
    chk("int_wait_exc", 32'(execption), 32'd0);
    m_valid = 1; m_pc = 32'h80004000;
    tick(); clear_inputs(); interupt = 0;
    chk("int_exc", 32'(execption), 32'd1);
    chk("int_code", 32'(exc_code), 32'd0);
    chk("int_epc", exc_epc, 32'h80004000);
    finish_event("int", 32'hBFC00380);

    // Pending interrupt beats ERET
    interupt = 1;
    tick();
    m_valid = 1; m_pc = 32'h80005000; m_eret = 1; epc_in = 32'h80006000;
    tick(); clear_inputs(); interupt = 0;
    chk("interet_exc", 32'(execption), 32'd1);
    chk("interet_ret", 32'(ret), 32'd0);
    chk("interet_code", 32'(exc_code), 32'd0);
    chk("interet_epc", exc_epc, 32'h80005000);
    finish_event("interet", 32'hBFC00380);

    // Reset during second flush cycle
    m_valid = 1; m_pc = 32'h80007000; m_sys = 1;
    tick(); clear_inputs();
    chk("rstf_code", 32'(exc_code), 32'd8);
    tick();
    chk("rstf_flush2", 32'(flush), 32'd1);
    rst = 1;
    tick();
    chk("rstf_flush", 32'(flush), 32'd0);
    chk("rstf_rvalid", 32'(redir_valid), 32'd0);
    chk("rstf_m_ready", 32'(m_ready), 32'd0);
    rst = 0;
    #1;
    chk("rstf_ready_back", 32'(m_ready), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Exception commit controller; sits directly upstream of the CP0 register file.
- Collects per-instruction exception flags from the memory/commit pipeline stage and the CP0 interrupt line, and selects one event by priority.
- Drives the CP0 exception/return inputs (one-cycle pulses with cause, EPC, BD and BadVaddr).
- Flushes the pipeline for a fixed number of cycles, then hands a redirect PC to fetch over a valid/ready handshake.

Parameters:
- EXC_VECTOR, 32'hBFC00380, PC fetched after any exception.
- FLUSH_CYCLES, 2, cycles `flush` stays high before the redirect is offered (range 1..15).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- m_valid  in  1  commit-stage instruction valid
- m_ready  out  1  controller accepts the commit-stage instruction
- m_pc  in  32  commit-stage instruction PC
- m_bd  in  1  instruction is in a branch delay slot
- m_adel_if  in  1  fetch address error
- m_ri  in  1  reserved instruction
- m_sys  in  1  syscall
- m_bp  in  1  break
- m_ov  in  1  arithmetic overflow
- m_adel_d  in  1  load address error
- m_ades  in  1  store address error
- m_eret  in  1  ERET instruction
- m_daddr  in  32  data address for load/store
- interupt  in  1  CP0 interrupt request (level)
- status_exl  in  1  CP0 Status.EXL
- epc_in  in  32  CP0 EPC (return address)
- execption  out  1  one-cycle exception pulse to CP0
- return  out  1  one-cycle ERET pulse to CP0
- exc_code  out  5  Cause.ExcCode
- exc_epc  out  32  EPC value
- exc_bd  out  1  Cause.BD
- exc_badvaddr  out  32  BadVAddr value
- flush  out  1  kill all younger pipeline stages
- redir_valid  out  1  redirect PC valid
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  32  redirect target

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; all outputs 0 (including m_ready and redir_pc); int_pend cleared; flush counter cleared. Reset mid-operation aborts any flush/redirect in the same edge.
- int_pend register: each cycle int_pend <= interupt & ~status_exl; cleared in the cycle an interrupt is taken.
- m_ready = (state==IDLE) & ~rst. An instruction is "accepted" when m_valid & m_ready.
- Event selection on an accepted instruction, highest priority first:
  - int_pend: code 0
  - m_adel_if: code 4, BadVaddr = m_pc
  - m_ri: code 10
  - m_sys: code 8
  - m_bp: code 9
  - m_ov: code 12
  - m_adel_d: code 4, BadVaddr = m_daddr
  - m_ades: code 5, BadVaddr = m_daddr
  - m_eret: return event, only when no exception is selected.
- For non-address exceptions exc_badvaddr = 0.
- EPC = m_bd ? m_pc - 32'd4 : m_pc (mod 2^32). exc_bd = m_bd.
- Exception event at edge N:
  - Cycle N+1: execption=1 with exc_code/exc_epc/exc_bd/exc_badvaddr valid; flush=1; state FLUSH.
  - Cause fields hold their values until the next event.
- Return event at edge N:
  - Cycle N+1: return=1; flush=1; target latched from epc_in at edge N; state FLUSH.
- No event on an accepted instruction: it retires; no output change.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles.
  - execption/return are high only in the first of those cycles.
  - Then state REDIRECT.
- REDIRECT:
  - flush=0; redir_valid=1; redir_pc = EXC_VECTOR (exception) or the latched EPC (return).
  - redir_pc stays stable while redir_ready=0.
  - The handshake completes on the edge where redir_valid & redir_ready; redir_valid=0 the next cycle; state IDLE.
- m_valid and all flags are ignored outside IDLE; an interrupt arriving then stays in int_pend.
- Simultaneous int_pend and m_eret: the interrupt wins (code 0, EPC of the ERET instruction).
- m_valid=0 with int_pend=1: no event; the interrupt waits for the next valid instruction.

Test Plan:
- Overflow: m_valid=1, m_pc=32'h80001000, m_ov=1 -> next cycle execption=1, exc_code=12, exc_epc=32'h80001000, exc_bd=0; flush high 2 cycles; redir_pc=32'hBFC00380.
- Delay-slot store error: m_pc=32'h80002004, m_bd=1, m_ades=1, m_daddr=32'h00000003 -> exc_code=5, exc_epc=32'h80002000, exc_bd=1, exc_badvaddr=32'h00000003.
- Priority: m_adel_if=1 and m_ri=1 on m_pc=32'h80000002 -> exc_code=4, exc_badvaddr=32'h80000002.
- ERET: epc_in=32'h80003000, m_eret=1 -> return=1, execption=0; redir_pc=32'h80003000; redir_ready held low 3 cycles keeps redir_valid=1 with a stable PC.
- Interrupt gating: interupt=1, status_exl=1 -> no event. Then status_exl=0 and one valid instruction at 32'h80004000 -> exc_code=0, exc_epc=32'h80004000.
- Reset in FLUSH: assert rst during the second flush cycle -> next cycle flush=0, redir_valid=0, m_ready=0; after rst deasserts, m_ready=1.
